// File: rtl/mem_arbiter_pkg.sv
// Shared control types for the instruction/data memory arbiter.
// Holds the arbiter state and grant encodings plus the round-robin pick rule.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

  localparam logic [3:0]  BE_FULL         = 4'b1111;
  localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

  // On a tie the requester that did not win last time is chosen.
  function automatic grant_e rr_pick(input logic i_req, input logic d_req, input grant_e last);
    if (i_req && d_req) begin
      return (last == GRANT_D) ? GRANT_I : GRANT_D;
    end else if (d_req) begin
      return GRANT_D;
    end else begin
      return GRANT_I;
    end
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single downstream memory port.
// Downstream signals come only from registers latched at grant time.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned RESET_PRIO = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_address,
  input  logic        imem_read,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_address,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_byte_enable,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  arb_state_e  state_q, state_d;
  grant_e      last_q, last_d;
  grant_e      pick;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        dmem_req;

  always_comb begin
    dmem_req = dmem_read | dmem_write;
    pick     = rr_pick(imem_read, dmem_req, last_q);
    state_d  = state_q;
    last_d   = last_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    unique case (state_q)
      IDLE: begin
        if (imem_read || dmem_req) begin
          last_d = pick;
          if (pick == GRANT_D) begin
            state_d = SERVE_D;
            addr_d  = dmem_address;
            wdata_d = dmem_wdata;
            be_d    = dmem_byte_enable;
            wr_d    = dmem_write;
            rd_d    = !dmem_write;
          end else begin
            state_d = SERVE_I;
            addr_d  = imem_address;
            wdata_d = '0;
            be_d    = BE_FULL;
            rd_d    = 1'b1;
            wr_d    = 1'b0;
          end
        end
      end
      SERVE_I, SERVE_D: begin
        if (mem_resp) begin
          state_d = IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= (RESET_PRIO != 0) ? GRANT_I : GRANT_D;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  // A requester that dropped its request (flush) gets no completion pulse.
  assign imem_resp  = !rst && mem_resp && (state_q == SERVE_I) && imem_read;
  assign dmem_resp  = !rst && mem_resp && (state_q == SERVE_D) && dmem_req;
  assign imem_rdata = imem_resp ? mem_rdata : '0;
  assign dmem_rdata = dmem_resp ? mem_rdata : '0;

  assign mem_address     = addr_q & ADDR_ALIGN_MASK;
  assign mem_read        = rd_q;
  assign mem_write       = wr_q;
  assign mem_wdata       = wdata_q;
  assign mem_byte_enable = be_q;

  assert property (@(posedge clk) disable iff (rst) !(dmem_read && dmem_write))
    else $error("mem_arbiter: dmem_read and dmem_write asserted together");

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter with a transaction-level reference model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_address, imem_rdata;
  logic        imem_read, imem_resp;
  logic [31:0] dmem_address, dmem_wdata, dmem_rdata;
  logic        dmem_read, dmem_write, dmem_resp;
  logic [3:0]  dmem_byte_enable;
  logic [31:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, mem_resp;
  logic [3:0]  mem_byte_enable;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.RESET_PRIO(1)) dut (
    .clk(clk), .rst(rst),
    .imem_address(imem_address), .imem_read(imem_read),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_address(dmem_address), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // reference-model state for the random phase
  bit          busy, owner_d, exp_wr, last_d;
  bit          p_busy, p_resp, p_i, p_d, pd_wr;
  logic [31:0] e_addr, e_wd, pi_addr, pd_addr, pd_wd;
  logic [3:0]  e_be, pd_be;
  bit          i_pend, d_pend, d_wr, exp_ir, exp_dr;

  initial begin
    rst = 1'b1;
    imem_address = '0; imem_read = 1'b0;
    dmem_address = '0; dmem_read = 1'b0; dmem_write = 1'b0;
    dmem_wdata = '0; dmem_byte_enable = '0;
    mem_rdata = '0; mem_resp = 1'b0;
    tick(); tick();
    chk1("rst_mem_read", mem_read, 1'b0);
    chk1("rst_mem_write", mem_write, 1'b0);
    chk1("rst_imem_resp", imem_resp, 1'b0);
    chk1("rst_dmem_resp", dmem_resp, 1'b0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_be", 32'(mem_byte_enable), 32'h0);

    // single fetch, response on the third strobe cycle
    rst = 1'b0; imem_read = 1'b1; imem_address = 32'h6000_0004;
    tick(); #1;
    chk1("fetch_mem_read_n1", mem_read, 1'b1);
    chk1("fetch_mem_write", mem_write, 1'b0);
    chk("fetch_mem_address", mem_address, 32'h6000_0004);
    chk("fetch_mem_be", 32'(mem_byte_enable), 32'hF);
    chk1("fetch_no_early_resp", imem_resp, 1'b0);
    tick(); #1;
    chk1("fetch_hold", mem_read, 1'b1);
    tick(); mem_resp = 1'b1; mem_rdata = 32'h0000_0013; #1;
    chk1("fetch_imem_resp", imem_resp, 1'b1);
    chk("fetch_imem_rdata", imem_rdata, 32'h0000_0013);
    chk1("fetch_dmem_resp", dmem_resp, 1'b0);
    tick(); mem_resp = 1'b0; imem_read = 1'b0; #1;
    chk1("fetch_done_read", mem_read, 1'b0);
    chk("fetch_rdata_zero", imem_rdata, 32'h0);

    // tie right after reset: dmem first, one idle cycle, then imem
    rst = 1'b1; tick(); rst = 1'b0;
    imem_read = 1'b1; imem_address = 32'h0000_0100;
    dmem_read = 1'b1; dmem_address = 32'h0000_0200;
    tick(); mem_resp = 1'b1; mem_rdata = 32'h0000_00AA; #1;
    chk("rr_first_addr", mem_address, 32'h0000_0200);
    chk1("rr_first_dresp", dmem_resp, 1'b1);
    chk("rr_first_drdata", dmem_rdata, 32'h0000_00AA);
    chk1("rr_first_iresp", imem_resp, 1'b0);
    tick(); mem_resp = 1'b0; dmem_read = 1'b0; #1;
    chk1("rr_gap_read", mem_read, 1'b0);
    tick(); mem_resp = 1'b1; #1;
    chk1("rr_second_read", mem_read, 1'b1);
    chk("rr_second_addr", mem_address, 32'h0000_0100);
    chk1("rr_second_iresp", imem_resp, 1'b1);
    tick(); mem_resp = 1'b0; imem_read = 1'b0; #1;
    chk1("rr_done_read", mem_read, 1'b0);

    // misaligned store: latched, aligned and held while the inputs wander
    dmem_write = 1'b1; dmem_address = 32'h0000_1003;
    dmem_byte_enable = 4'b1000; dmem_wdata = 32'hAB00_0000;
    for (int k = 0; k < 4; k++) begin
      tick();
      dmem_address = $urandom; dmem_wdata = $urandom; dmem_byte_enable = 4'($urandom);
      mem_resp = (k == 3); mem_rdata = 32'h0000_0005; #1;
      chk1("st_mem_write", mem_write, 1'b1);
      chk1("st_mem_read", mem_read, 1'b0);
      chk("st_mem_address", mem_address, 32'h0000_1000);
      chk("st_mem_be", 32'(mem_byte_enable), 32'h8);
      chk("st_mem_wdata", mem_wdata, 32'hAB00_0000);
      chk1("st_dmem_resp", dmem_resp, k == 3);
    end
    tick(); mem_resp = 1'b0; dmem_write = 1'b0; #1;
    chk1("st_done_write", mem_write, 1'b0);

    // fetch flushed one cycle after grant
    imem_read = 1'b1; imem_address = 32'h0000_0044;
    tick(); #1;
    chk1("flush_grant", mem_read, 1'b1);
    tick(); imem_read = 1'b0; #1;
    chk1("flush_hold1", mem_read, 1'b1);
    tick(); #1;
    chk1("flush_hold2", mem_read, 1'b1);
    tick(); mem_resp = 1'b1; mem_rdata = 32'hDEAD_BEEF; #1;
    chk1("flush_hold3", mem_read, 1'b1);
    chk1("flush_no_resp", imem_resp, 1'b0);
    chk("flush_rdata_zero", imem_rdata, 32'h0);
    tick(); mem_resp = 1'b0; #1;
    chk1("flush_done", mem_read, 1'b0);

    // reset during a data transaction
    dmem_read = 1'b1; dmem_address = 32'h0000_0080;
    tick(); #1;
    chk1("abort_grant", mem_read, 1'b1);
    tick(); rst = 1'b1; mem_resp = 1'b1; #1;
    chk1("abort_no_dresp", dmem_resp, 1'b0);
    tick(); rst = 1'b0; mem_resp = 1'b0; dmem_read = 1'b0; #1;
    chk1("abort_read_low", mem_read, 1'b0);
    chk1("abort_write_low", mem_write, 1'b0);
    chk("abort_addr_clr", mem_address, 32'h0);

    // both requesters continuously pending: D,I,D,I,...
    imem_read = 1'b1; imem_address = 32'h0000_1000;
    dmem_read = 1'b1; dmem_address = 32'h0000_2000;
    for (int t = 0; t < 8; t++) begin
      tick(); mem_resp = 1'b1; #1;
      chk("alt_addr", mem_address, (t % 2 == 0) ? 32'h0000_2000 : 32'h0000_1000);
      chk1("alt_dresp", dmem_resp, t % 2 == 0);
      chk1("alt_iresp", imem_resp, t % 2 == 1);
      tick(); mem_resp = 1'b0;
      imem_read = (t < 7); dmem_read = (t < 7); #1;
      chk1("alt_gap", mem_read, 1'b0);
    end

    // randomized traffic against the transaction-level model
    rst = 1'b1; tick(); rst = 1'b0;
    busy = 0; owner_d = 0; exp_wr = 0; last_d = 0;
    p_busy = 0; p_resp = 0; p_i = 0; p_d = 0;
    i_pend = 0; d_pend = 0; d_wr = 0;
    e_addr = '0; e_wd = '0; e_be = '0;
    for (int c = 0; c < 800; c++) begin
      tick();
      if (p_busy && p_resp) begin
        busy = 0;
      end else if (!p_busy && (p_i || p_d)) begin
        owner_d = p_d && (!p_i || !last_d);
        last_d  = owner_d;
        busy    = 1;
        if (owner_d) begin
          e_addr = pd_addr & 32'hFFFF_FFFC; e_be = pd_be; e_wd = pd_wd; exp_wr = pd_wr;
        end else begin
          e_addr = pi_addr & 32'hFFFF_FFFC; e_be = 4'hF; exp_wr = 0;
        end
      end
      chk1("rnd_mem_read", mem_read, busy && !exp_wr);
      chk1("rnd_mem_write", mem_write, busy && exp_wr);
      if (busy) begin
        chk("rnd_mem_address", mem_address, e_addr);
        chk("rnd_mem_be", 32'(mem_byte_enable), 32'(e_be));
        if (owner_d) chk("rnd_mem_wdata", mem_wdata, e_wd);
      end

      if (!i_pend && $urandom_range(1, 0) == 1) begin
        i_pend = 1; imem_address = $urandom;
      end else if (busy && !owner_d) begin
        imem_address = $urandom;
      end
      if (!d_pend && $urandom_range(1, 0) == 1) begin
        d_pend = 1; d_wr = ($urandom_range(1, 0) == 1);
        dmem_address = $urandom; dmem_wdata = $urandom; dmem_byte_enable = 4'($urandom);
      end else if (busy && owner_d) begin
        dmem_address = $urandom; dmem_wdata = $urandom; dmem_byte_enable = 4'($urandom);
      end
      imem_read  = i_pend;
      dmem_read  = d_pend && !d_wr;
      dmem_write = d_pend && d_wr;
      mem_resp   = busy ? ($urandom_range(2, 0) == 0) : ($urandom_range(4, 0) == 0);
      mem_rdata  = $urandom;
      #1;
      exp_ir = mem_resp && busy && !owner_d;
      exp_dr = mem_resp && busy && owner_d;
      chk1("rnd_imem_resp", imem_resp, exp_ir);
      chk1("rnd_dmem_resp", dmem_resp, exp_dr);
      chk("rnd_imem_rdata", imem_rdata, exp_ir ? mem_rdata : 32'h0);
      chk("rnd_dmem_rdata", dmem_rdata, exp_dr ? mem_rdata : 32'h0);

      p_busy = busy; p_resp = mem_resp && busy;
      p_i = imem_read; p_d = dmem_read || dmem_write;
      pi_addr = imem_address; pd_addr = dmem_address;
      pd_wd = dmem_wdata; pd_be = dmem_byte_enable; pd_wr = dmem_write;
      if (exp_ir) i_pend = 0;
      if (exp_dr) d_pend = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
